studio2_keypad: RTL

//  Upstream input stage for the Studio II core: turns MiSTer ps2_key events into two 10-key
//  hex keypads (digits 0-9) and emulates the console's key-select latch. CPU OUT 2 writes the
//  key number to test; EF3_n/EF4_n report whether that key is down on keypad 1/2.

---
 rtl/studio2_keypad_if.sv | 23 ++
 rtl/studio2_keypad.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/studio2_keypad_if.sv
// Bus-side signals of the Studio II keypad stage.
// PS/2 events and CPU OUT cycles come in; keypad state and EF flags go out.
interface studio2_keypad_if;
  logic [10:0] ps2_key;
  logic        io_out;
  logic [2:0]  io_n;
  logic [7:0]  cpu_dout;
  logic [3:0]  key_sel;
  logic [9:0]  kp1_down;
  logic [9:0]  kp2_down;
  logic        EF3_n;
  logic        EF4_n;

  modport master (
    output ps2_key, io_out, io_n, cpu_dout,
    input  key_sel, kp1_down, kp2_down, EF3_n, EF4_n
  );

  modport slave (
    input  ps2_key, io_out, io_n, cpu_dout,
    output key_sel, kp1_down, kp2_down, EF3_n, EF4_n
  );
endinterface

// File: rtl/studio2_keypad.sv
// Studio II keypad input stage: PS/2 set-2 scancodes drive two 10-key keypads with
// release stretch; a CPU-written select latch picks the key reported on EF3_n/EF4_n.
module studio2_keypad #(
  parameter int STRETCH_W = 5,
  parameter int STRETCH   = 20
) (
  input logic             clk_sys,
  input logic             reset_n,
  studio2_keypad_if.slave bus
);

  typedef enum logic [1:0] {ST_UP, ST_DOWN, ST_HOLD} key_state_t;

  localparam logic [STRETCH_W-1:0] HOLD_LOAD =
    (STRETCH > 0) ? STRETCH_W'(STRETCH - 1) : '0;

  logic        r_armed;
  logic        r_old_tgl;
  logic [3:0]  r_key_sel;
  logic        r_ef3_n;
  logic        r_ef4_n;
  logic        w_evt;
  logic        w_press;
  logic [19:0] w_code;
  logic [19:0] w_hit;
  logic [19:0] w_down;
  logic [9:0]  w_sel1;
  logic [9:0]  w_sel2;
  logic        w_unused;

  assign w_unused = ^bus.cpu_dout[7:4];

  // armed suppresses a phantom event from whatever toggle level was present at reset.
  assign w_evt   = r_armed && (bus.ps2_key[10] != r_old_tgl);
  assign w_press = bus.ps2_key[9];

  // One-hot key decode: bits 0-9 keypad 1, bits 10-19 keypad 2.
  always_comb begin
    w_code = '0;
    case (bus.ps2_key[7:0])
      8'h45: w_code[0]  = 1'b1;
      8'h16: w_code[1]  = 1'b1;
      8'h1E: w_code[2]  = 1'b1;
      8'h26: w_code[3]  = 1'b1;
      8'h25: w_code[4]  = 1'b1;
      8'h2E: w_code[5]  = 1'b1;
      8'h36: w_code[6]  = 1'b1;
      8'h3D: w_code[7]  = 1'b1;
      8'h3E: w_code[8]  = 1'b1;
      8'h46: w_code[9]  = 1'b1;
      8'h70: w_code[10] = 1'b1;
      8'h69: w_code[11] = 1'b1;
      8'h72: w_code[12] = 1'b1;
      8'h7A: w_code[13] = 1'b1;
      8'h6B: w_code[14] = 1'b1;
      8'h73: w_code[15] = 1'b1;
      8'h74: w_code[16] = 1'b1;
      8'h6C: w_code[17] = 1'b1;
      8'h75: w_code[18] = 1'b1;
      8'h7D: w_code[19] = 1'b1;
      default: w_code = '0;
    endcase
  end

  assign w_hit = (w_evt && !bus.ps2_key[8]) ? w_code : '0;

  genvar gi;
  for (gi = 0; gi < 20; gi++) begin : g_key
    key_state_t           r_state;
    key_state_t           w_state_next;
    logic [STRETCH_W-1:0] r_cnt;
    logic [STRETCH_W-1:0] w_cnt_next;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= ST_UP;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
        ST_UP: begin
          if (w_hit[gi] && w_press) w_state_next = ST_DOWN;
        end
        ST_DOWN: begin
          if (w_hit[gi] && !w_press) begin
            if (STRETCH == 0) begin
              w_state_next = ST_UP;
            end else begin
              w_state_next = ST_HOLD;
              w_cnt_next   = HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          // A break while already releasing does not restart the stretch.
          if (w_hit[gi] && w_press) begin
            w_state_next = ST_DOWN;
            w_cnt_next   = '0;
          end else if (r_cnt == '0) begin
            w_state_next = ST_UP;
          end else begin
            w_cnt_next = r_cnt - STRETCH_W'(1);
          end
        end
        default: w_state_next = ST_UP;
      endcase
    end

    assign w_down[gi] = (r_state != ST_UP);
  end

  // Select values 10-15 match no digit, so both flags stay high.
  for (gi = 0; gi < 10; gi++) begin : g_sel
    assign w_sel1[gi] = (r_key_sel == 4'(gi)) && w_down[gi];
    assign w_sel2[gi] = (r_key_sel == 4'(gi)) && w_down[gi + 10];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_armed   <= 1'b0;
      r_old_tgl <= 1'b0;
      r_key_sel <= 4'd0;
      r_ef3_n   <= 1'b1;
      r_ef4_n   <= 1'b1;
    end else begin
      r_armed   <= 1'b1;
      r_old_tgl <= bus.ps2_key[10];
      if (bus.io_out && bus.io_n == 3'd2) r_key_sel <= bus.cpu_dout[3:0];
      r_ef3_n   <= ~|w_sel1;
      r_ef4_n   <= ~|w_sel2;
    end
  end

  assign bus.key_sel  = r_key_sel;
  assign bus.kp1_down = w_down[9:0];
  assign bus.kp2_down = w_down[19:10];
  assign bus.EF3_n    = r_ef3_n;
  assign bus.EF4_n    = r_ef4_n;

endmodule
